pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DW, default 32, register write-data width.
REQ-002 Parameter AW, default 5, register write-address width.
REQ-003 clk_i  input  1  single clock; all state updates on posedge clk_i.
REQ-004 rst_i  input  1  reset; synchronous, active-low (`RstEnable` = 1'b0).
REQ-005 valid_i  input  1  upstream stage presents a valid payload.
REQ-006 ready_o  output  1  stage can accept a payload; driven directly from a flop.
REQ-007 reg_waddr_i  input  AW  destination register address.
REQ-008 reg_we_i  input  1  register write enable.
REQ-009 reg_wdata_i  input  DW  register write data.
REQ-010 flush_i  input  1  discard all held and incoming payloads.
REQ-011 valid_o  output  1  downstream payload valid.
REQ-012 ready_i  input  1  downstream accepts the payload; low means stall.
REQ-013 reg_waddr_o / reg_we_o / reg_wdata_o  output  AW / 1 / DW  registered payload.
REQ-014 occ_o  output  2  occupancy: 0, 1 or 2 entries held.

Function
REQ-015 A push occurs when valid_i and ready_o are both high; a pop occurs when valid_o and ready_i are both high.
REQ-016 Storage is two slots, main (drives the outputs) and skid; the FSM states are EMPTY, ONE and TWO, encoded as occ_o = 0, 1 and 2.
REQ-017 EMPTY with push goes to ONE, with main loaded from the inputs; with no push it stays EMPTY.
REQ-018 ONE with push and pop stays ONE, with main loaded from the inputs; push only goes to TWO, with skid loaded from the inputs; pop only goes to EMPTY; with neither it holds.
REQ-019 TWO with pop goes to ONE, with main loaded from skid; with no pop it holds all state.
REQ-020 Push is impossible in TWO because ready_o is low.
REQ-021 ready_o is registered high when the next state is EMPTY or ONE, and low when the next state is TWO.
REQ-022 valid_o is high exactly in ONE and TWO.
REQ-023 reg_we_o equals main.we AND valid_o, so no write is ever presented while the stage is empty.
REQ-024 Latency from a push to that payload appearing at the outputs is 1 cycle.
REQ-025 Sustained throughput is 1 payload per cycle while ready_i stays high.
REQ-026 Ordering is strict FIFO, and no payload is duplicated or dropped except by flush.
REQ-027 flush_i high forces the next state to EMPTY, valid_o 0, ready_o 1 and occ_o 0.
REQ-028 flush_i has priority over a simultaneous push and pop, and a payload pushed in that cycle is discarded.
REQ-029 Payload registers not loaded in a cycle retain their value; their contents are don't-care whenever valid_o is 0, except that reg_we_o is still gated to 0.
REQ-030 Width rules: payload fields are passed bit-exact, with no extension or truncation.

Reset
REQ-031 While rst_i is low at a clock edge, the stage enters EMPTY, and inputs and flush_i are ignored in that cycle.
REQ-032 Reset values: valid_o 0, ready_o 1, occ_o 0, reg_waddr_o `ZeroReg`, reg_we_o `WriteDisable`, reg_wdata_o `ZeroWord`, and skid slot all zero.
REQ-033 Reset asserted mid-operation, including in TWO, discards both slots at the same edge.

Structure
REQ-034 `RstEnable`, `ZeroWord`, `ZeroReg`, `WriteDisable`, `RegBus` and `RegAddrBus` come from the shared defines.v.
REQ-035 The FSM state encodings (EMPTY/ONE/TWO) are added to the shared defines.v.
REQ-036 One sub-module, pipe_slot, holds a parametrised payload register with load enable and synchronous clear; it is instantiated twice, as main and skid.
REQ-037 No combinational path exists from ready_i to ready_o.

Verification
REQ-038 Reset then stream: rst_i low 2 cycles, then valid_i=1 and ready_i=1 with waddr 1..4 and wdata 0xA0..0xA3 -> valid_o rises 1 cycle later, outputs show 1..4 back-to-back, and occ_o stays 1.
REQ-039 Stall fill: in ONE holding waddr=3, push waddr=5 with ready_i=0 -> occ_o=2 and ready_o=0 next cycle; then ready_i=1 -> outputs show 3 then 5, and ready_o returns to 1 one cycle after the first pop.
REQ-040 Flush in TWO with simultaneous push -> next cycle valid_o=0, reg_we_o=0, occ_o=0, ready_o=1, and the pushed payload never appears.
REQ-041 Empty gating: reg_we_i=1 pushed, popped, with no further input -> reg_we_o=0 while valid_o=0, even though main.we holds 1.
REQ-042 Reset in TWO -> at the next edge all outputs take their REQ-032 values, and a subsequent push of waddr=7 appears after 1 cycle.
REQ-043 Random valid_i, ready_i and flush_i for 10k cycles -> a scoreboard confirms FIFO order, no loss outside flush, and ready_o=0 only when occ_o=2.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants and FSM encoding for the register-write skid stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_skid_stage_pkg;

  // Reset level and default payload values shared across the pipeline.
  localparam logic        RstEnable    = 1'b0;
  localparam logic        WriteDisable = 1'b0;
  localparam int          RegBus       = 32;
  localparam int          RegAddrBus   = 5;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg      = 5'b00000;

  // Occupancy-encoded states: the state value doubles as occ_o.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// Payload holding register with load enable and synchronous clear.
// Latency: 1 cycle from ld to q.
// Backpressure: none; holds its value whenever ld is low.
module pipe_slot #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load; otherwise retain the value when not loaded.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= CLR_VAL;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage for register-write payloads (main + skid slot).
// Latency: 1 cycle push-to-output; 1 payload/cycle sustained throughput.
// Backpressure: ready_o is a flop, low only while both slots are full.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DW = RegBus,
  parameter int AW = RegAddrBus
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [AW-1:0] reg_waddr_i,
  input  logic          reg_we_i,
  input  logic [DW-1:0] reg_wdata_i,
  input  logic          flush_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [AW-1:0] reg_waddr_o,
  output logic          reg_we_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic [1:0]    occ_o
);

  // Payload layout: {we, waddr, wdata}.
  localparam int           PW      = DW + AW + 1;
  localparam logic [PW-1:0] CLR_PAY = {WriteDisable, AW'(ZeroReg), DW'(ZeroWord)};

  state_e        state;
  state_e        nxt;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          main_ld;
  logic          main_from_skid;
  logic          skid_ld;
  logic          slot_clr;
  logic [PW-1:0] in_pay;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign slot_clr = (rst_i == RstEnable);
  assign in_pay   = {reg_we_i, reg_waddr_i, reg_wdata_i};
  assign main_d   = main_from_skid ? skid_q : in_pay;

  assign valid_o  = (state != ST_EMPTY);
  assign ready_o  = ready_q;
  assign occ_o    = state;
  assign push     = valid_i & ready_q;
  assign pop      = valid_o & ready_i;

  assign reg_we_o    = main_q[PW-1] & valid_o;
  assign reg_waddr_o = main_q[DW +: AW];
  assign reg_wdata_o = main_q[DW-1:0];

  // State and ready flop; ready is precomputed from the next state so
  // ready_i never reaches ready_o combinationally.
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= nxt;
      ready_q <= (nxt != ST_TWO);
    end
  end

  // Next-state and slot load control; flush overrides any push or pop.
  always_comb begin
    nxt            = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush_i) begin
      nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            nxt     = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            nxt     = ST_TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            nxt            = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(PW), .CLR_VAL(CLR_PAY)) u_main (
    .clk (clk_i),
    .clr (slot_clr),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_slot #(.W(PW), .CLR_VAL(CLR_PAY)) u_skid (
    .clk (clk_i),
    .clr (slot_clr),
    .ld  (skid_ld),
    .d   (in_pay),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of the register-write skid stage.
// Latency: n/a.
// Backpressure: drives ready_i directly to exercise stalls.
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  logic [AW-1:0] reg_waddr_i;
  logic          reg_we_i;
  logic [DW-1:0] reg_wdata_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [AW-1:0] reg_waddr_o;
  logic          reg_we_o;
  logic [DW-1:0] reg_wdata_o;
  logic [1:0]    occ_o;

  int checks = 0;
  int errors = 0;

  pipe_skid_stage #(.DW(DW), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .reg_wdata_i (reg_wdata_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .occ_o       (occ_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] d, input logic rdy, input logic fl);
    valid_i     = v;
    reg_waddr_i = a;
    reg_we_i    = we;
    reg_wdata_i = d;
    ready_i     = rdy;
    flush_i     = fl;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 64'(valid_o), 64'd0);
    chk({tag, ".ready"}, 64'(ready_o), 64'd1);
    chk({tag, ".occ"},   64'(occ_o),   64'd0);
    chk({tag, ".waddr"}, 64'(reg_waddr_o), 64'd0);
    chk({tag, ".we"},    64'(reg_we_o),    64'd0);
    chk({tag, ".wdata"}, 64'(reg_wdata_o), 64'd0);
  endtask

  logic [AW+DW:0] model_q[$];
  logic [AW+DW:0] got_pay;
  logic [AW+DW:0] in_pay;
  logic           do_push;
  logic           do_pop;
  logic [DW-1:0]  seq;

  initial begin
    // Reset with valid input held high: it must be ignored.
    rst_i = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    tick();
    chk_reset_vals("rst");

    // Back-to-back stream 1..4.
    rst_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(k + 1), 1'b1, 32'hA0 + 32'(k), 1'b1, 1'b0);
      tick();
      chk("stream.valid", 64'(valid_o), 64'd1);
      chk("stream.waddr", 64'(reg_waddr_o), 64'(k + 1));
      chk("stream.wdata", 64'(reg_wdata_o), 64'hA0 + 64'(k));
      chk("stream.occ",   64'(occ_o), 64'd1);
      chk("stream.ready", 64'(ready_o), 64'd1);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("stream.drain.valid", 64'(valid_o), 64'd0);
    chk("stream.drain.occ",   64'(occ_o), 64'd0);

    // Stall fill: hold 3, push 5 while stalled, then drain.
    drive(1'b1, 5'd3, 1'b1, 32'h33, 1'b0, 1'b0);
    tick();
    chk("fill.one.occ", 64'(occ_o), 64'd1);
    drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    chk("fill.two.occ",   64'(occ_o), 64'd2);
    chk("fill.two.ready", 64'(ready_o), 64'd0);
    chk("fill.two.waddr", 64'(reg_waddr_o), 64'd3);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("fill.pop1.waddr", 64'(reg_waddr_o), 64'd5);
    chk("fill.pop1.wdata", 64'(reg_wdata_o), 64'h55);
    chk("fill.pop1.ready", 64'(ready_o), 64'd1);
    chk("fill.pop1.occ",   64'(occ_o), 64'd1);
    tick();
    chk("fill.pop2.valid", 64'(valid_o), 64'd0);

    // Flush in TWO with input valid.
    drive(1'b1, 5'd8, 1'b1, 32'h88, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 1'b0);
    tick();
    chk("flush2.pre.occ", 64'(occ_o), 64'd2);
    drive(1'b1, 5'd10, 1'b1, 32'hAA, 1'b1, 1'b1);
    tick();
    chk("flush2.valid", 64'(valid_o), 64'd0);
    chk("flush2.we",    64'(reg_we_o), 64'd0);
    chk("flush2.occ",   64'(occ_o), 64'd0);
    chk("flush2.ready", 64'(ready_o), 64'd1);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("flush2.after.valid", 64'(valid_o), 64'd0);

    // Flush in ONE with a simultaneous real push: pushed payload is dropped.
    drive(1'b1, 5'd12, 1'b1, 32'hC0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd11, 1'b1, 32'hB0, 1'b1, 1'b1);
    tick();
    chk("flush1.occ", 64'(occ_o), 64'd0);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("flush1.after.valid", 64'(valid_o), 64'd0);

    // Empty gating of the write enable.
    drive(1'b1, 5'd2, 1'b1, 32'h22, 1'b1, 1'b0);
    tick();
    chk("gate.we.live", 64'(reg_we_o), 64'd1);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("gate.valid", 64'(valid_o), 64'd0);
    chk("gate.we",    64'(reg_we_o), 64'd0);
    tick();
    chk("gate.we.hold", 64'(reg_we_o), 64'd0);

    // Reset while full, then a fresh push.
    drive(1'b1, 5'd13, 1'b1, 32'hD0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd14, 1'b1, 32'hE0, 1'b0, 1'b0);
    tick();
    chk("rst2.pre.occ", 64'(occ_o), 64'd2);
    rst_i = 1'b0;
    tick();
    chk_reset_vals("rst2");
    rst_i = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 32'h77, 1'b1, 1'b0);
    tick();
    chk("rst2.push.valid", 64'(valid_o), 64'd1);
    chk("rst2.push.waddr", 64'(reg_waddr_o), 64'd7);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("rst2.drain.occ", 64'(occ_o), 64'd0);

    // Random traffic against a queue model.
    seq = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            seq, ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
      do_push = valid_i & ready_o;
      do_pop  = valid_o & ready_i;
      in_pay  = {reg_we_i, reg_waddr_i, reg_wdata_i};
      got_pay = {reg_we_o, reg_waddr_o, reg_wdata_o};
      if (do_pop) begin
        if (model_q.size() == 0) begin
          chk("rand.pop.unexpected", 64'(do_pop), 64'd0);
        end else begin
          chk("rand.pop.data", 64'(got_pay), 64'(model_q[0] & {1'b1, {(AW+DW){1'b1}}}));
          void'(model_q.pop_front());
        end
      end
      if (flush_i) begin
        model_q.delete();
      end else if (do_push) begin
        model_q.push_back(in_pay);
        seq = seq + 32'd1;
      end
      tick();
      chk("rand.occ",   64'(occ_o), 64'(model_q.size()));
      chk("rand.ready", 64'(ready_o), 64'(model_q.size() != 2));
      chk("rand.valid", 64'(valid_o), 64'(model_q.size() != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
